// File: rtl/project_gen_if.sv
// Bus between the slot-projection engine and its requester / two-bank FFT BRAM.
interface project_gen_if #(
  parameter int unsigned LOGN_MAX     = 15,
  parameter int unsigned FLP_WORDSIZE = 64
);
  localparam int unsigned LogNW = $clog2(LOGN_MAX + 1);
  localparam int unsigned AddrW = LOGN_MAX - 1;
  localparam int unsigned DataW = 2 * FLP_WORDSIZE;

  // Control handshake
  logic             start;
  logic [LogNW-1:0] log_n;
  logic             gen_sel;
  logic             inverse;
  logic             busy;
  logic             done;
  logic             err;

  // BRAM port: shared addresses, per-bank write enables
  logic [AddrW-1:0] fft_rd_addr;
  logic [AddrW-1:0] fft_wr_addr;
  logic             fft_bank0_wea;
  logic             fft_bank1_wea;
  logic [DataW-1:0] fft_bank0_rd_data;
  logic [DataW-1:0] fft_bank1_rd_data;
  logic [DataW-1:0] fft_wr_data;

  // Engine side
  modport slave (
    input  start, log_n, gen_sel, inverse, fft_bank0_rd_data, fft_bank1_rd_data,
    output busy, done, err, fft_rd_addr, fft_wr_addr, fft_bank0_wea, fft_bank1_wea,
    output fft_wr_data
  );

  // Requester / memory side
  modport master (
    output start, log_n, gen_sel, inverse, fft_bank0_rd_data, fft_bank1_rd_data,
    input  busy, done, err, fft_rd_addr, fft_wr_addr, fft_bank0_wea, fft_bank1_wea,
    input  fft_wr_data
  );
endinterface

// File: rtl/project_gen.sv
// Slot-projection engine: walks the rotation group g^j mod 2N, folds the index through
// bit reversal and moves N/2 complex slots between the source and destination regions
// of a two-bank FFT BRAM, conjugating slots whose fold crosses the half-ring.
module project_gen #(
  parameter int unsigned LOGN_MIN     = 13,
  parameter int unsigned LOGN_MAX     = 15,
  parameter int unsigned FLP_WORDSIZE = 64,
  parameter int unsigned BRAM_RD_LAT  = 2   // must be >= 1
) (
  input logic          clk,
  input logic          rst_n,
  project_gen_if.slave bus
);
  localparam int unsigned LogNW = $clog2(LOGN_MAX + 1);
  localparam int unsigned AW    = LOGN_MAX - 1;   // step / word index / address width
  localparam int unsigned PW    = LOGN_MAX + 1;   // position register width
  localparam int unsigned DW    = 2 * FLP_WORDSIZE;
  localparam int unsigned CW    = (BRAM_RD_LAT > 1) ? $clog2(BRAM_RD_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [LogNW-1:0] r_log_n;
  logic             r_gen5;
  logic             r_inv;
  logic [AW-1:0]    r_j;
  logic [PW-1:0]    r_pos;
  logic [CW-1:0]    r_drain_cnt;
  logic             r_err;

  // Read-to-write alignment pipeline, one entry per cycle of BRAM latency
  logic             r_pipe_vld  [BRAM_RD_LAT];
  logic             r_pipe_bank [BRAM_RD_LAT];
  logic             r_pipe_conj [BRAM_RD_LAT];
  logic [AW-1:0]    r_pipe_word [BRAM_RD_LAT];

  logic             w_idle_like, w_cfg_ok, w_accept, w_reject;
  logic [PW-1:0]    w_n, w_s, w_mask, w_pos_next;
  logic [AW-1:0]    w_s_last;
  logic [LOGN_MAX-1:0] w_half, w_rev, w_idx;
  logic             w_conj;
  logic [AW-1:0]    w_a, w_rd_word, w_wr_word;
  logic             w_wr_vld, w_wr_bank;
  logic [DW-1:0]    w_sel_data, w_conj_mask;

  // Start qualification; the done cycle behaves like idle so passes can chain
  assign w_idle_like = (r_state == StIdle) || (r_state == StDone);
  assign w_cfg_ok    = (32'(bus.log_n) >= LOGN_MIN) && (32'(bus.log_n) <= LOGN_MAX);
  assign w_accept    = w_idle_like && bus.start && w_cfg_ok;
  assign w_reject    = w_idle_like && bus.start && !w_cfg_ok;

  // Ring geometry for the captured degree
  assign w_n        = PW'(1) << r_log_n;
  assign w_s        = w_n >> 1;
  assign w_s_last   = AW'(w_s - PW'(1));
  assign w_mask     = w_n | (w_n - PW'(1));     // M-1 = 2N-1
  assign w_pos_next = ((r_gen5 ? (r_pos << 2) : (r_pos << 1)) + r_pos) & w_mask;

  // pos is always odd, so (pos-1)>>1 is an exact log_n-bit index
  assign w_half = LOGN_MAX'((r_pos - PW'(1)) >> 1);

  // Full-width bit reversal, realigned below to the runtime degree
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < int'(LOGN_MAX); i++) begin
      w_rev[i] = w_half[LOGN_MAX-1-i];
    end
  end

  assign w_idx     = w_rev >> (LogNW'(LOGN_MAX) - r_log_n);
  assign w_conj    = ({1'b0, w_idx} >= w_s);
  assign w_a       = w_conj ? AW'(w_n - PW'(1) - {1'b0, w_idx}) : AW'(w_idx);
  assign w_rd_word = r_inv ? r_j : w_a;
  assign w_wr_word = r_inv ? w_a : r_j;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // FSM next state
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle, StDone: w_state_d = w_accept ? StIssue : StIdle;
      StIssue:        if (r_j == w_s_last) w_state_d = StDrain;
      StDrain:        if (r_drain_cnt == CW'(BRAM_RD_LAT - 1)) w_state_d = StDone;
      default:        w_state_d = StIdle;
    endcase
  end

  // Config capture, step/position walk, drain counter and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_log_n     <= '0;
      r_gen5      <= 1'b0;
      r_inv       <= 1'b0;
      r_j         <= '0;
      r_pos       <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_log_n <= bus.log_n;
        r_gen5  <= bus.gen_sel;
        r_inv   <= bus.inverse;
        r_j     <= '0;
        r_pos   <= PW'(1);
      end else if (r_state == StIssue) begin
        r_j   <= r_j + AW'(1);
        r_pos <= w_pos_next;
      end
      if (r_state == StIssue)      r_drain_cnt <= '0;
      else if (r_state == StDrain) r_drain_cnt <= r_drain_cnt + CW'(1);
    end
  end

  // Carry bank select, conjugate flag and write word alongside the BRAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BRAM_RD_LAT); i++) begin
        r_pipe_vld[i]  <= 1'b0;
        r_pipe_bank[i] <= 1'b0;
        r_pipe_conj[i] <= 1'b0;
        r_pipe_word[i] <= '0;
      end
    end else begin
      r_pipe_vld[0]  <= (r_state == StIssue);
      r_pipe_bank[0] <= w_rd_word[0];
      r_pipe_conj[0] <= w_conj;
      r_pipe_word[0] <= w_wr_word;
      for (int i = 1; i < int'(BRAM_RD_LAT); i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_bank[i] <= r_pipe_bank[i-1];
        r_pipe_conj[i] <= r_pipe_conj[i-1];
        r_pipe_word[i] <= r_pipe_word[i-1];
      end
    end
  end

  assign w_wr_vld    = r_pipe_vld[BRAM_RD_LAT-1];
  assign w_wr_bank   = r_pipe_word[BRAM_RD_LAT-1][0];
  assign w_sel_data  = r_pipe_bank[BRAM_RD_LAT-1] ? bus.fft_bank1_rd_data
                                                  : bus.fft_bank0_rd_data;
  // Sign bit of the imaginary (low) word
  assign w_conj_mask = {{(DW-1){1'b0}}, r_pipe_conj[BRAM_RD_LAT-1]} << (FLP_WORDSIZE - 1);

  // Outputs are gated so that every one of them reads 0 while held in reset
  assign bus.busy          = (r_state == StIssue) || (r_state == StDrain);
  assign bus.done          = (r_state == StDone);
  assign bus.err           = r_err;
  assign bus.fft_rd_addr   = (r_state == StIssue) ? {1'b0, w_rd_word[AW-1:1]} : '0;
  assign bus.fft_wr_addr   = w_wr_vld ? {1'b1, r_pipe_word[BRAM_RD_LAT-1][AW-1:1]} : '0;
  assign bus.fft_bank0_wea = w_wr_vld && !w_wr_bank;
  assign bus.fft_bank1_wea = w_wr_vld && w_wr_bank;
  assign bus.fft_wr_data   = w_wr_vld ? (w_sel_data ^ w_conj_mask) : '0;

endmodule
